// File: rtl/ntt_io_sequencer.sv
// ntt_io_sequencer: serial load/unload sequencer around an NTT core; define NTT_IO_RANGE_CHECK_EN for input range checking on err.
module ntt_io_sequencer #(
  parameter int WIDTH = 32,
  parameter int SIZE = 257,
  parameter int ROWS = 4,
  parameter int MEM_DELAY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5:0]              cfg_mod_idx,
  input  logic [WIDTH-1:0]        cfg_modulus,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WIDTH-1:0]        s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [WIDTH-1:0]        m_data,
  output logic                    m_last,
  output logic                    ntt_start,
  output logic [5:0]              ntt_mod_idx,
  input  logic                    ntt_done,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [8*SIZE-1:0]       mem_addr,
  output logic [WIDTH*SIZE-1:0]   din,
  input  logic [WIDTH*SIZE-1:0]   dout,
  output logic                    busy,
  output logic                    err
);
  localparam int KW = SIZE > 1 ? $clog2(SIZE) : 1;
  localparam int DW = MEM_DELAY > 0 ? $clog2(MEM_DELAY + 1) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(SIZE - 1);
  localparam logic [7:0] R_LAST = 8'(ROWS - 1);
  localparam logic [DW-1:0] D_LAST = DW'(MEM_DELAY);
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, START, WAIT, READ, CAPTURE, UNLOAD} state_t;
  state_t state, state_n;
  logic [KW-1:0] k, k_n;
  logic [7:0] row, row_n;
  logic [DW-1:0] d, d_n;
  logic [WIDTH*SIZE-1:0] row_buf;
  logic s_acc, m_acc, k_end;
  assign s_acc = s_valid && s_ready;
  assign m_acc = m_valid && m_ready;
  assign k_end = k == K_LAST;
  // The row buffer and row counter are flops, so these stay registered outputs.
  assign din = row_buf;
  assign mem_addr = {SIZE{row}};
  always_comb begin
    state_n = state;
    k_n = k;
    row_n = row;
    d_n = d;
    case (state)
      IDLE, LOAD: if (s_acc) begin
        k_n = k_end ? '0 : k + 1'b1;
        state_n = k_end ? WRITE : LOAD;
      end
      WRITE: begin
        row_n = row + 8'd1;
        state_n = row == R_LAST ? START : LOAD;
      end
      START: state_n = WAIT;
      WAIT: if (ntt_done) begin
        row_n = '0;
        d_n = '0;
        state_n = READ;
      end
      READ: begin
        d_n = d == D_LAST ? '0 : d + 1'b1;
        state_n = d == D_LAST ? CAPTURE : READ;
      end
      CAPTURE: begin
        k_n = '0;
        state_n = UNLOAD;
      end
      UNLOAD: if (m_acc) begin
        k_n = k_end ? '0 : k + 1'b1;
        row_n = k_end ? (row == R_LAST ? '0 : row + 8'd1) : row;
        state_n = k_end ? (row == R_LAST ? IDLE : READ) : UNLOAD;
      end
      default: state_n = IDLE;
    endcase
  end
  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      k <= '0;
      row <= '0;
      d <= '0;
      row_buf <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      m_data <= '0;
      ntt_start <= 1'b0;
      ntt_mod_idx <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      k <= k_n;
      row <= row_n;
      d <= d_n;
      s_ready <= state_n == IDLE || state_n == LOAD;
      m_valid <= state_n == UNLOAD;
      m_last <= state_n == UNLOAD && k_n == K_LAST && row_n == R_LAST;
      m_data <= row_buf[int'(k_n)*WIDTH +: WIDTH];
      ntt_start <= state_n == START;
      mem_read <= state_n == READ;
      mem_write <= state_n == WRITE;
      busy <= state_n != IDLE;
      if (s_acc && state == IDLE) ntt_mod_idx <= cfg_mod_idx;
      if (s_acc) row_buf[int'(k)*WIDTH +: WIDTH] <= s_data;
      if (state == READ && d == D_LAST) row_buf <= dout;
    end
  end
`ifdef NTT_IO_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= 1'b0;
    else if (s_acc) err <= (state == LOAD && err) || s_data >= cfg_modulus;
  end
`else
  logic unused_modulus;
  assign unused_modulus = ^cfg_modulus;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_ntt_io_sequencer.sv
// tb_ntt_io_sequencer: drives full transforms through a fake core memory and checks the streams against a word-level model.
module tb_ntt_io_sequencer;
  localparam int WIDTH = 32, SIZE = 257, ROWS = 4, MEM_DELAY = 2, N = SIZE * ROWS;
`ifdef NTT_IO_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, s_valid, s_ready, m_valid, m_ready, m_last, ntt_start, ntt_done;
  logic mem_read, mem_write, busy, err;
  logic [5:0] cfg_mod_idx, ntt_mod_idx;
  logic [WIDTH-1:0] cfg_modulus, s_data, m_data;
  logic [8*SIZE-1:0] mem_addr;
  logic [WIDTH*SIZE-1:0] din, dout;
  logic [WIDTH-1:0] in_w [N];
  logic [WIDTH-1:0] mem [256][SIZE];
  logic [WIDTH-1:0] rd1 [SIZE];
  int cmps = 0, errs = 0;
  int wcnt = 0, oidx = 0, rd_run = 0, rd_row_exp = 0, starts = 0, cyc;
  logic done_seen = 1'b0, prev_stall = 1'b0, exp_err = 1'b0;
  logic [5:0] exp_idx = '0;
  logic [WIDTH-1:0] prev_data, row2_b0, first_out, last_out;

  ntt_io_sequencer #(.WIDTH(WIDTH), .SIZE(SIZE), .ROWS(ROWS), .MEM_DELAY(MEM_DELAY)) dut (
    .clk(clk), .reset(reset), .cfg_mod_idx(cfg_mod_idx), .cfg_modulus(cfg_modulus),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .ntt_start(ntt_start), .ntt_mod_idx(ntt_mod_idx), .ntt_done(ntt_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .din(din), .dout(dout), .busy(busy), .err(err));

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] f(input logic [WIDTH-1:0] x);
    return x * 32'd3 + 32'd7;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Fake core: stores f(din) per bank, returns it MEM_DELAY cycles after the read address.
  always @(posedge clk) begin
    for (int b = 0; b < SIZE; b++) begin
      logic [7:0] a;
      a = mem_addr[8*b +: 8];
      if (mem_write) mem[a][b] <= f(din[WIDTH*b +: WIDTH]);
      if (mem_read) rd1[b] <= mem[a][b];
      dout[WIDTH*b +: WIDTH] <= rd1[b];
    end
  end

  always @(negedge clk) if (reset) begin
    check("err", err, exp_err);
    if (mem_read || mem_write) check("strobe_excl", mem_read & mem_write, 0);
    if (ntt_start) begin
      starts++;
      check("start_idx", ntt_mod_idx, exp_idx);
    end
    if (mem_write) begin
      if (wcnt < ROWS) begin
        check("wr_row", mem_addr[7:0], wcnt);
        check("wr_row_top", mem_addr[8*SIZE-1 -: 8], wcnt);
        check("wr_din0", din[WIDTH-1:0], in_w[wcnt*SIZE]);
        check("wr_din_last", din[WIDTH*SIZE-1 -: WIDTH], in_w[wcnt*SIZE+SIZE-1]);
        if (wcnt == 2) row2_b0 = din[WIDTH-1:0];
      end else check("wr_extra", wcnt, ROWS - 1);
      wcnt++;
    end
    if (mem_read) begin
      if (rd_run == 0) begin
        check("rd_after_done", done_seen, 1);
        check("rd_row", mem_addr[7:0], rd_row_exp);
      end
      rd_run++;
    end else if (rd_run != 0) begin
      check("rd_hold", rd_run, MEM_DELAY + 1);
      rd_run = 0;
      rd_row_exp++;
    end
    if (m_valid) begin
      if (oidx < N) begin
        check("m_data", m_data, f(in_w[oidx]));
        check("m_last", m_last, oidx == N - 1);
      end else check("m_extra", oidx, N - 1);
      if (prev_stall) check("m_hold", m_data, prev_data);
      if (oidx == 0) first_out = m_data;
      if (oidx == N - 1) last_out = m_data;
      prev_stall = !m_ready;
      prev_data = m_data;
      if (m_ready) oidx++;
    end else begin
      prev_stall = 1'b0;
      if (m_last) check("m_last_idle", m_last, 0);
    end
  end

  task automatic send(input logic [WIDTH-1:0] v, input bit first);
    int n = 0;
    s_valid = 1'b1;
    s_data = v;
    while (!s_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("s_ready_wait", s_ready, 1);
    @(posedge clk); #1;
    exp_err = RC && ((first ? 1'b0 : exp_err) || v >= cfg_modulus);
  endtask

  task automatic load(input int count, input logic [5:0] idx, input int done_at);
    for (int i = 0; i < count; i++) begin
      cfg_mod_idx = i == 0 ? idx : ~idx;
      ntt_done = i == done_at;
      send(in_w[i], i == 0);
    end
    s_valid = 1'b0;
    ntt_done = 1'b0;
  endtask

  task automatic transform(input int base, input logic [5:0] idx, input int done_at, input bit toggle);
    int n, strobes;
    for (int i = 0; i < N; i++) in_w[i] = 32'(base + i);
    wcnt = 0; oidx = 0; rd_row_exp = 0; starts = 0; done_seen = 1'b0; prev_stall = 1'b0; exp_idx = idx;
    load(N, idx, done_at);
    n = 0;
    while (!ntt_start && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("start_pulse", ntt_start, 1);
    check("write_pulses", wcnt, ROWS);
    check("wait_s_ready", s_ready, 0);
    check("wait_busy", busy, 1);
    strobes = 0;
    repeat (50) begin
      @(posedge clk); #1;
      strobes += int'(mem_read | mem_write);
    end
    check("wait_strobes", strobes, 0);
    check("start_once", starts, 1);
    ntt_done = 1'b1;
    done_seen = 1'b1;
    @(posedge clk); #1;
    ntt_done = 1'b0;
    check("rd_next_cycle", mem_read, 1);
    check("rd_first_row", mem_addr[7:0], 0);
    m_ready = 1'b1;
    n = 0;
    while (oidx < N && n < 6000) begin
      @(posedge clk); #1;
      n++;
      if (toggle) m_ready = ~m_ready;
    end
    cyc = n;
    m_ready = 1'b0;
    check("out_words", oidx, N);
    check("read_rows", rd_row_exp, ROWS);
    check("end_busy", busy, 0);
    check("end_s_ready", s_ready, 1);
  endtask

  initial begin
    reset = 1'b0; s_valid = 1'b0; s_data = '0; cfg_mod_idx = '0; cfg_modulus = 32'd97;
    m_ready = 1'b0; ntt_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_strobes", {ntt_start, mem_read, mem_write, m_last}, 0);
    check("rst_err", err, 0);
    check("rst_mod_idx", ntt_mod_idx, 0);
    check("rst_addr_din", {|mem_addr, |din}, 0);
    reset = 1'b1;
    #1 check("rel_s_ready_before_edge", s_ready, 0);
    @(posedge clk); #1;
    check("rel_s_ready", s_ready, 1);
    check("rel_busy", busy, 0);
    check("rel_strobes", {mem_read, mem_write}, 0);

    transform(0, 6'd37, 50, 1'b1);
    check("mod_idx_37", ntt_mod_idx, 37);
    check("row2_bank0", row2_b0, 514);
    check("first_out", first_out, 7);
    check("last_out", last_out, 3088);

    for (int i = 0; i < N; i++) in_w[i] = 32'(i * 7);
    wcnt = 0;
    load(100, 6'd3, -1);
    reset = 1'b0;
    exp_err = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_s_ready", s_ready, 0);
    check("abort_din", |din, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_strobe", {mem_read, mem_write}, 0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_no_write", wcnt, 0);
    check("restart_s_ready", s_ready, 1);
    check("restart_busy", busy, 0);

    transform(5000, 6'd12, -1, 1'b0);
    check("mod_idx_12", ntt_mod_idx, 12);
    check("row2_bank0_b", row2_b0, 5514);
    check("unload_cycles", cyc, ROWS * (SIZE + MEM_DELAY + 2));
    check("first_out_b", first_out, 15007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

  initial begin
    #1000000;
    errs++;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ntt_io_sequencer.md
NTT_IO_SEQUENCER -- requirements
Module: ntt_io_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: coefficient width in bits.
REQ-002 SHALL have parameter SIZE, default 257: coefficients per memory row (one per bank).
REQ-003 SHALL have parameter ROWS, default 4, range 1-256: rows per transform.
REQ-004 SHALL have parameter MEM_DELAY, default 2: core memory read latency in cycles.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 cfg_mod_idx  input  6  modulus index, sampled at transform start.
REQ-008 cfg_modulus  input  WIDTH  modulus value used for range checking.
REQ-009 s_valid / s_ready / s_data  input / output / input  1 / 1 / WIDTH  serial coefficient input stream.
REQ-010 m_valid / m_ready / m_data / m_last  output / input / output / output  1 / 1 / WIDTH / 1  serial result stream.
REQ-011 ntt_start, ntt_mod_idx  output  1, 6  core start pulse and modulus index.
REQ-012 ntt_done  input  1  core done pulse.
REQ-013 mem_read, mem_write  output  1 each  core host-port read and write enables.
REQ-014 mem_addr  output  8*SIZE  per-bank address; every bank carries the same row index.
REQ-015 din / dout  output / input  WIDTH*SIZE  core row write data / row read data.
REQ-016 busy, err  output  1 each  transform in progress; sticky range error.

Function
REQ-017 SHALL use the states IDLE, LOAD, WRITE, START, WAIT, READ, CAPTURE, UNLOAD.
REQ-018 IDLE: s_ready=1. The first s_valid&&s_ready latches cfg_mod_idx into ntt_mod_idx, stores the word, and moves to LOAD.
REQ-019 LOAD: s_ready=1. Accepted words fill the row buffer at positions 0..SIZE-1 in arrival order. The SIZE-th accepted word moves the FSM to WRITE.
REQ-020 WRITE: for exactly one cycle, mem_write=1, mem_addr={SIZE{row}}, din=row buffer, s_ready=0. Then row increments; the FSM goes to LOAD if row<ROWS-1, else to START.
REQ-021 START: ntt_start=1 for exactly one cycle, then WAIT.
REQ-022 WAIT: mem_read=0 and mem_write=0. The FSM stays until ntt_done=1, then goes to READ with row=0. An ntt_done seen in any other state SHALL be ignored.
REQ-023 READ: mem_read=1 and mem_addr={SIZE{row}} are held for MEM_DELAY+1 cycles. In the last of those cycles dout is captured into the row buffer, and the FSM goes to CAPTURE.
REQ-024 CAPTURE lasts one cycle and then goes to UNLOAD.
REQ-025 UNLOAD: m_valid=1 and m_data=buffer[k], with k from 0 to SIZE-1. k advances only on m_valid&&m_ready. m_data is stable while m_ready=0.
REQ-026 m_last=1 on k=SIZE-1 of row ROWS-1 only.
REQ-027 After the last word of a row is accepted: go to READ with row+1 if more rows remain, else go to IDLE.
REQ-028 Counters: k is ceil(log2(SIZE)) bits wide and wraps to 0 at SIZE-1. row is 8 bits wide and wraps to 0 at transform end.
REQ-029 busy=1 in every state except IDLE.
REQ-030 s_ready=0 in all states other than IDLE and LOAD. Input backpressure persists until the transform completes.
REQ-031 mem_read and mem_write SHALL never be asserted in the same cycle.
REQ-032 All outputs SHALL be registered.
REQ-033 In UNLOAD, throughput SHALL be one word per cycle while m_ready=1.

Reset
REQ-034 While reset=0, SHALL asynchronously force: state=IDLE, row=0, k=0, s_ready=0, m_valid=0, m_last=0, ntt_start=0, mem_read=0, mem_write=0, busy=0, err=0, ntt_mod_idx=0, mem_addr=0, din=0.
REQ-035 s_ready SHALL rise on the first clk edge after reset deasserts.
REQ-036 Reset asserted mid-transform SHALL abort the transform with no further memory access.

Configuration
REQ-037 The macro NTT_IO_RANGE_CHECK_EN SHALL control input range checking.
- Defined: any accepted s_data >= cfg_modulus sets err=1 on the next edge. err is cleared only by reset or by the first accept in IDLE. The data is still written unchanged.
- Undefined: err is tied to 0 and no comparator is built.

Verification
REQ-038 Reset release: after reset=0 then 1, the next cycle shows s_ready=1, busy=0, and all memory strobes are 0.
REQ-039 ROWS=4 load: 1028 words with values 0..1027 produce exactly 4 mem_write pulses on rows 0..3. Row 2 din bank 0 = 514. One ntt_start follows, with ntt_mod_idx equal to the value sampled at the first accept.
REQ-040 Unload with m_ready toggled 1,0,1,0 after ntt_done: output words equal the dout model row-wise, each word is held during stalls, and m_last is set only on word 1027.
REQ-041 Done timing: ntt_done asserted in LOAD is ignored. ntt_done asserted 50 cycles after start produces mem_read with row 0 on the next cycle, held for 3 cycles.
REQ-042 Reset mid-LOAD: assert reset=0 at word 100. No mem_write occurs afterwards, and a new transform starts row 0 cleanly.
REQ-043 With NTT_IO_RANGE_CHECK_EN and cfg_modulus=97: input word 97 sets err=1 the cycle after acceptance, and err stays 1 through m_last. Without the macro, err stays 0.
